i2s_sample_fifo_irq: RTL and testbench

Buffers audio samples from the I2S deserializer in a small synchronous FIFO and raises the interrupt request that drives interrupt_enable on the Raspberry Pi interrupt clock generator directly downstream. The request asserts when the buffered level reaches a threshold. It holds until the Pi drains the FIFO to empty. It then stays low for a guaranteed holdoff, so the downstream clock counter fully resets before the next request. Everything runs on the 50 MHz codec clock domain.

---
 rtl/i2s_sample_fifo_irq.sv | 110 +++++++++++
 tb/tb_i2s_sample_fifo_irq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_fifo_irq.sv
// i2s_sample_fifo_irq: sample FIFO with a level-threshold interrupt request and a post-drain holdoff
// Ports:
//   i_clk_in        50 MHz codec clock, rising-edge
//   i_reset_n       asynchronous active-low reset
//   i_sample_data   sample word from the I2S deserializer
//   i_sample_valid  one-cycle write strobe
//   i_rd_en         one-cycle read strobe (already synchronous to i_clk_in)
//   i_ovf_clr       one-cycle clear of the sticky overflow flag
//   o_rd_data       registered read word
//   o_rd_valid      pulses one cycle after an accepted read
//   o_irq_enable    interrupt request to the downstream interrupt clock generator
//   o_level         FIFO occupancy 0..DEPTH
//   o_empty/o_full  decoded from o_level
//   o_overflow      sticky, set when a sample is dropped
module i2s_sample_fifo_irq #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 4,
   parameter int THRESHOLD = 8,
   parameter int HOLDOFF   = 4
) (
   input  logic              i_clk_in,
   input  logic              i_reset_n,
   input  logic [DATA_W-1:0] i_sample_data,
   input  logic              i_sample_valid,
   input  logic              i_rd_en,
   input  logic              i_ovf_clr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic              o_irq_enable,
   output logic [ADDR_W:0]   o_level,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_overflow
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LVL_FULL = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] LVL_TH   = THRESHOLD[ADDR_W:0];
   localparam logic [7:0]      HO_CNT   = HOLDOFF[7:0];
   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLDOFF} state_t;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_W:0]   r_level;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid, r_overflow, r_irq;
   logic [7:0]        r_cnt;
   state_t            r_state;
   logic              w_rd, w_wr, w_drop;
   assign o_empty      = r_level == '0;
   assign o_full       = r_level == LVL_FULL;
   assign o_level      = r_level;
   assign o_rd_data    = r_rd_data;
   assign o_rd_valid   = r_rd_valid;
   assign o_overflow   = r_overflow;
   assign o_irq_enable = r_irq;
   assign w_rd   = i_rd_en & ~o_empty;
   // a full FIFO still takes a write when a read frees a slot in the same cycle
   assign w_wr   = i_sample_valid & (~o_full | w_rd);
   assign w_drop = i_sample_valid & o_full & ~w_rd;
   always_ff @(posedge i_clk_in) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_sample_data;
   end
   always_ff @(posedge i_clk_in or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_data <= r_mem[r_rd_ptr];
         end
         r_rd_valid <= w_rd;
         r_level    <= (w_wr & ~w_rd) ? r_level + 1'b1 : (w_rd & ~w_wr) ? r_level - 1'b1 : r_level;
         // a drop in the same cycle as a clear leaves the flag set
         r_overflow <= w_drop | (r_overflow & ~i_ovf_clr);
      end
   end
   // irq is registered alongside the state so it always equals (state == S_ASSERT)
   always_ff @(posedge i_clk_in or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_irq   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (r_level >= LVL_TH) begin
               r_state <= S_ASSERT;
               r_irq   <= 1'b1;
            end
            S_ASSERT: if (r_level == '0) begin
               r_state <= S_HOLDOFF;
               r_cnt   <= HO_CNT;
               r_irq   <= 1'b0;
            end
            S_HOLDOFF: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == 8'd1) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_irq   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2s_sample_fifo_irq.sv
// tb_i2s_sample_fifo_irq: table vectors, directed corner sequences and randomized traffic against a queue model
module tb_i2s_sample_fifo_irq;
   localparam int DEPTH = 16;
   localparam int TH    = 8;
   localparam int HO    = 4;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] sample_data = '0;
   logic        sample_valid = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
   logic [31:0] rd_data;
   logic        rd_valid, irq_enable, empty, full, overflow;
   logic [4:0]  level;
   int n_chk = 0, n_pass = 0;
   i2s_sample_fifo_irq dut (
      .i_clk_in(clk), .i_reset_n(reset_n), .i_sample_data(sample_data),
      .i_sample_valid(sample_valid), .i_rd_en(rd_en), .i_ovf_clr(ovf_clr),
      .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_irq_enable(irq_enable),
      .o_level(level), .o_empty(empty), .o_full(full), .o_overflow(overflow));
   always #5 clk = ~clk;
   logic [31:0] mq[$];
   logic [31:0] m_rd_data;
   logic        m_rd_valid, m_ovf, m_irq;
   int          t, quiet_until;
   task automatic model_reset();
      mq.delete();
      m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
      t = 0; quiet_until = -100;
   endtask
   // request rises once the level seen at an edge reaches TH and no quiet window is running;
   // it falls when the level seen at an edge is zero and then stays off for HO edges
   task automatic model_edge(input logic sv, input logic [31:0] sd, input logic re, input logic oc);
      int  lvl;
      logic rd, wr, drop;
      t++;
      lvl  = mq.size();
      rd   = re && lvl > 0;
      wr   = sv && (lvl < DEPTH || rd);
      drop = sv && lvl == DEPTH && !rd;
      if (m_irq && lvl == 0) begin
         m_irq = 1'b0;
         quiet_until = t + HO;
      end else if (!m_irq && t > quiet_until && lvl >= TH) m_irq = 1'b1;
      m_rd_valid = rd;
      if (rd) m_rd_data = mq.pop_front();
      if (wr) mq.push_back(sd);
      m_ovf = drop ? 1'b1 : (oc ? 1'b0 : m_ovf);
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s at t=%0d: got %h expected %h", nm, t, act, exp);
      else n_pass++;
   endtask
   task automatic check_model();
      chk("level", 32'(level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      chk("rd_data", rd_data, m_rd_data);
      chk("irq_enable", 32'(irq_enable), 32'(m_irq));
   endtask
   task automatic step(input logic sv, input logic [31:0] sd, input logic re, input logic oc);
      sample_valid = sv; sample_data = sd; rd_en = re; ovf_clr = oc;
      @(posedge clk);
      model_edge(sv, sd, re, oc);
      #1;
      sample_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
   endtask
   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask
   typedef struct {
      logic        sv;
      logic [31:0] sd;
      logic        re;
      logic        oc;
      int          lvl;
      logic        irq;
      logic        rv;
      logic [31:0] rdat;
      logic        ovf;
   } vec_t;
   vec_t tbl[22];
   initial begin
      for (int k = 0; k < 8; k++) tbl[k] = '{1'b1, 32'h11110000 + k, 1'b0, 1'b0, k + 1, 1'b0, 1'b0, 32'h0, 1'b0};
      tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 32'h0, 1'b0};
      for (int k = 0; k < 8; k++) tbl[9 + k] = '{1'b0, 32'h0, 1'b1, 1'b0, 7 - k, 1'b1, 1'b1, 32'h11110000 + k, 1'b0};
      for (int k = 0; k < 5; k++) tbl[17 + k] = '{1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h11110007, 1'b0};
      model_reset();
      do_reset();
      #1;
      check_model();
      for (int i = 0; i < 50; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0);
         check_model();
      end
      do_reset();
      for (int i = 0; i < 22; i++) begin
         step(tbl[i].sv, tbl[i].sd, tbl[i].re, tbl[i].oc);
         chk($sformatf("tbl%0d level", i), 32'(level), 32'(tbl[i].lvl));
         chk($sformatf("tbl%0d irq", i), 32'(irq_enable), 32'(tbl[i].irq));
         chk($sformatf("tbl%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
         chk($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].rdat);
         chk($sformatf("tbl%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
         check_model();
      end
      for (int k = 0; k < 12; k++) begin
         step(k < 8, 32'h22220000 + k, 1'b0, 1'b0);
         check_model();
      end
      chk("reassert", 32'(irq_enable), 32'd1);
      do_reset();
      for (int k = 0; k < 17; k++) begin
         step(1'b1, 32'h33330000 + k, 1'b0, 1'b0);
         check_model();
      end
      chk("ovf full", 32'(full), 32'd1);
      chk("ovf level", 32'(level), 32'd16);
      chk("ovf flag", 32'(overflow), 32'd1);
      step(1'b1, 32'h44440000, 1'b0, 1'b1);
      chk("ovf set wins", 32'(overflow), 32'd1);
      check_model();
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("ovf clr", 32'(overflow), 32'd0);
      check_model();
      step(1'b1, 32'h55550000, 1'b1, 1'b0);
      chk("simul full level", 32'(level), 32'd16);
      chk("simul full ovf", 32'(overflow), 32'd0);
      chk("simul full oldest", rd_data, 32'h33330000);
      check_model();
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0);
         check_model();
      end
      chk("last readback", rd_data, 32'h55550000);
      step(1'b1, 32'h66660000, 1'b1, 1'b0);
      chk("simul empty level", 32'(level), 32'd1);
      chk("simul empty rv", 32'(rd_valid), 32'd0);
      check_model();
      do_reset();
      for (int k = 0; k < 11; k++) begin
         step(k < 10, 32'h77770000 + k, 1'b0, 1'b0);
         check_model();
      end
      chk("pre-reset irq", 32'(irq_enable), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async irq drop", 32'(irq_enable), 32'd0);
      chk("async level", 32'(level), 32'd0);
      chk("async empty", 32'(empty), 32'd1);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0);
         check_model();
      end
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) < (ph == 0 ? 70 : ph == 1 ? 30 : 50), $urandom,
                 $urandom_range(99) < (ph == 0 ? 30 : ph == 1 ? 70 : 50), $urandom_range(99) < 3);
            check_model();
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
